pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset and lock-qualification sequencer
//
// Purpose:
//    Holds a PLL in reset for a fixed interval, waits for lock, requires the
//    lock to be stable for a number of cycles, then releases the downstream
//    system reset. A lock timeout or a lock loss while running triggers a
//    retry. After too many retries the block parks in FAULT until restart.
//
// Optional feature:
//    PLLSEQ_LOSS_FILTER_EN - when defined, a loss of lock in RUN must persist
//    for LOSS_FILTER consecutive cycles before it is acted on. When undefined,
//    a single unlocked cycle in RUN is a loss of lock.
//
// Ports:
//    refclk     in   reference clock, the only clock of this block
//    rst        in   asynchronous active-high reset
//    restart    in   synchronous pulse, restarts sequencing from any state
//    pll_locked in   PLL lock flag, asynchronous to refclk
//    pll_rst    out  reset to the PLL (high in PLL_RST and FAULT)
//    sys_rst    out  reset for PLL-clocked logic (low only in RUN)
//    ready      out  high only in RUN
//    fault      out  high only in FAULT
//    state      out  0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN 4=FAULT
//    retry_cnt  out  failed attempts since the last RUN entry or restart

module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 100000,
   parameter int unsigned STABLE_CYCLES = 256,
   parameter int unsigned MAX_RETRIES   = 3,
   parameter int unsigned LOSS_FILTER   = 4
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       restart,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [2:0] state,
   output logic [3:0] retry_cnt
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   // One shared cycle counter serves PLL_RST, WAIT_LOCK and STABLE. It is
   // 24 bits wide so it can reach the largest legal lock timeout; the
   // other two intervals are at most 16 bits.
   localparam logic [23:0] RST_LAST    = 24'(RST_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
   localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

   // Elaboration-time sanity check: a zero loss filter length is illegal and
   // leaves this marker block visible in the elaborated hierarchy.
   if (LOSS_FILTER == 0) begin : g_loss_filter_zero_illegal
   end

   logic        r_lock_meta;
   logic        r_lock_s;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [23:0] r_cnt;
   logic [23:0] w_cnt_nxt;
   logic [3:0]  r_retry;
   logic [3:0]  w_retry_nxt;
   logic        w_retry_req;
   logic        r_pll_rst;
   logic        r_sys_rst;
   logic        r_ready;
   logic        r_fault;

`ifdef PLLSEQ_LOSS_FILTER_EN
   localparam logic [15:0] LOSS_LAST = 16'(LOSS_FILTER - 1);
   logic [15:0] r_loss_cnt;
   logic [15:0] w_loss_cnt_nxt;
`endif

   // Two-flop synchronizer; nothing downstream looks at pll_locked directly.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= pll_locked;
         r_lock_s    <= r_lock_meta;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      w_retry_req = 1'b0;
`ifdef PLLSEQ_LOSS_FILTER_EN
      // Cleared everywhere except while counting a dropout in RUN.
      w_loss_cnt_nxt = '0;
`endif

      case (r_state)
         S_PLL_RST: begin
            if (r_cnt == RST_LAST) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
            end
         end

         S_WAIT_LOCK: begin
            if (r_lock_s) begin
               w_state_nxt = S_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_retry_req = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
            end
         end

         S_STABLE: begin
            // Chatter is not a failed attempt: fall back with a fresh
            // timeout and leave the retry count alone.
            if (!r_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
            end
         end

         S_RUN: begin
`ifdef PLLSEQ_LOSS_FILTER_EN
            if (r_lock_s) begin
               w_loss_cnt_nxt = '0;
            end else if (r_loss_cnt == LOSS_LAST) begin
               w_retry_req = 1'b1;
            end else begin
               w_loss_cnt_nxt = r_loss_cnt + 16'd1;
            end
`else
            if (!r_lock_s) begin
               w_retry_req = 1'b1;
            end
`endif
         end

         S_FAULT: begin
            // Parked until restart or rst.
         end

         default: begin
            w_state_nxt = S_PLL_RST;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
         end
      endcase

      // Shared retry action for timeouts and lock loss. The >= compare keeps
      // the counter from ever moving past the limit.
      if (w_retry_req) begin
         w_cnt_nxt = '0;
         if (r_retry >= RETRY_MAX) begin
            w_state_nxt = S_FAULT;
         end else begin
            w_state_nxt = S_PLL_RST;
            w_retry_nxt = r_retry + 4'd1;
         end
      end

      // Restart overrides every transition decided above.
      if (restart) begin
         w_state_nxt = S_PLL_RST;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
`ifdef PLLSEQ_LOSS_FILTER_EN
         w_loss_cnt_nxt = '0;
`endif
      end
   end

   // Outputs are registered from the next state so they change on the same
   // edge as the state register and always agree with it.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state   <= S_PLL_RST;
         r_cnt     <= '0;
         r_retry   <= '0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_retry   <= w_retry_nxt;
         r_pll_rst <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAULT);
         r_sys_rst <= (w_state_nxt != S_RUN);
         r_ready   <= (w_state_nxt == S_RUN);
         r_fault   <= (w_state_nxt == S_FAULT);
      end
   end

`ifdef PLLSEQ_LOSS_FILTER_EN
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_loss_cnt <= '0;
      end else begin
         r_loss_cnt <= w_loss_cnt_nxt;
      end
   end
`endif

   assign pll_rst   = r_pll_rst;
   assign sys_rst   = r_sys_rst;
   assign ready     = r_ready;
   assign fault     = r_fault;
   assign state     = r_state;
   assign retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;
   localparam int LOSS_FILTER   = 3;

   localparam logic [2:0] PRST  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] STAB  = 3'd2;
   localparam logic [2:0] RUN   = 3'd3;
   localparam logic [2:0] FLT   = 3'd4;

   logic       refclk = 1'b0;
   logic       rst;
   logic       restart;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [2:0] state;
   logic [3:0] retry_cnt;

   typedef struct {
      bit         restart;
      bit         locked;
      int         n;
      logic [2:0] st;
      logic [3:0] rc;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   pll_reset_sequencer #(
      .RST_CYCLES   (RST_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES),
      .LOSS_FILTER  (LOSS_FILTER)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .restart   (restart),
      .pll_locked(pll_locked),
      .pll_rst   (pll_rst),
      .sys_rst   (sys_rst),
      .ready     (ready),
      .fault     (fault),
      .state     (state),
      .retry_cnt (retry_cnt)
   );

   initial forever #5 refclk = ~refclk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got n_vec=%0d, required completion", n_vec);
      $fatal(1);
   end

   function automatic vec_t mk(bit rs, bit lk, int n, logic [2:0] st, logic [3:0] rc);
      vec_t v;
      v.restart = rs;
      v.locked  = lk;
      v.n       = n;
      v.st      = st;
      v.rc      = rc;
      return v;
   endfunction

   function automatic void add(bit rs, bit lk, int n, logic [2:0] st, logic [3:0] rc);
      tbl.push_back(mk(rs, lk, n, st, rc));
   endfunction

   // Output flags are derived from the expected state as the encoding
   // defines them, independently of the DUT.
   task automatic check(input string name, input vec_t e);
      logic [10:0] exp_o;
      logic [10:0] act_o;
      exp_o = {e.st, e.rc, (e.st == PRST) || (e.st == FLT), (e.st != RUN),
               (e.st == RUN), (e.st == FLT)};
      act_o = {state, retry_cnt, pll_rst, sys_rst, ready, fault};
      n_vec++;
      if (act_o !== exp_o) begin
         n_err++;
         $display("FAIL %s: got state=%0d retry=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b, expected state=%0d retry=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b",
                  name, state, retry_cnt, pll_rst, sys_rst, ready, fault,
                  exp_o[10:8], exp_o[7:4], exp_o[3], exp_o[2], exp_o[1], exp_o[0]);
      end
   endtask

   // Drive at a negedge, let n active edges pass, compare at the next negedge.
   task automatic apply_vec(input int id, input vec_t v);
      vec_t e;
      restart    = v.restart;
      pll_locked = v.locked;
      exp_q.push_back(v);
      repeat (v.n) @(posedge refclk);
      @(negedge refclk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", id), e);
   endtask

   initial begin
      rst        = 1'b1;
      restart    = 1'b0;
      pll_locked = 1'b1;
      repeat (3) @(negedge refclk);
      check("reset_hold", mk(0, 1, 0, PRST, 4'd0));
      rst = 1'b0;

      // Nominal bring-up with lock already present.
      add(0, 1, 3, PRST, 0);
      add(0, 1, 1, WAIT, 0);
      add(0, 1, 1, STAB, 0);
      add(0, 1, 7, STAB, 0);
      add(0, 1, 1, RUN,  0);
      // Two-cycle dropout in RUN.
      add(0, 0, 2, RUN,  0);
`ifdef PLLSEQ_LOSS_FILTER_EN
      add(0, 1, 2, RUN,  0);
`else
      add(0, 1, 2, PRST, 1);
      add(0, 1, 3, WAIT, 1);
      add(0, 1, 9, RUN,  0);
`endif
      // Three-cycle dropout in RUN.
`ifdef PLLSEQ_LOSS_FILTER_EN
      add(0, 0, 3, RUN,  0);
      add(0, 1, 1, RUN,  0);
`else
      add(0, 0, 3, PRST, 1);
      add(0, 1, 1, PRST, 1);
`endif
      add(0, 1, 1, PRST, 1);
      // Restart clears the retry count.
      add(1, 1, 1, PRST, 0);
      // Single-cycle chatter in STABLE.
      add(0, 1, 9, STAB, 0);
      add(0, 0, 1, STAB, 0);
      add(0, 1, 2, WAIT, 0);
      add(0, 1, 1, STAB, 0);
      add(0, 1, 7, STAB, 0);
      add(0, 1, 1, RUN,  0);
      // Repeated lock timeouts into FAULT.
      add(1, 0, 1,  PRST, 0);
      add(0, 0, 4,  WAIT, 0);
      add(0, 0, 19, WAIT, 0);
      add(0, 0, 1,  PRST, 1);
      add(0, 0, 4,  WAIT, 1);
      add(0, 0, 20, PRST, 2);
      add(0, 0, 4,  WAIT, 2);
      add(0, 0, 19, WAIT, 2);
      add(0, 0, 1,  FLT,  2);
      add(0, 1, 30, FLT,  2);
      // Restart out of FAULT, then restart coinciding with a timeout.
      add(1, 0, 1,  PRST, 0);
      add(0, 0, 4,  WAIT, 0);
      add(0, 0, 19, WAIT, 0);
      add(1, 0, 1,  PRST, 0);
      add(0, 0, 3,  PRST, 0);
      add(0, 0, 1,  WAIT, 0);
      add(0, 1, 3,  STAB, 0);

      foreach (tbl[i]) apply_vec(i, tbl[i]);

      // Asynchronous reset in the middle of STABLE, checked between edges.
      #2;
      rst = 1'b1;
      #1;
      check("rst_in_stable", mk(0, 1, 0, PRST, 4'd0));
      @(negedge refclk);
      @(negedge refclk);
      rst = 1'b0;

      // Fresh sequence after the mid-run reset.
      tbl.delete();
      add(0, 1, 3, PRST, 0);
      add(0, 1, 1, WAIT, 0);
      add(0, 1, 1, STAB, 0);
      add(0, 1, 7, STAB, 0);
      add(0, 1, 1, RUN,  0);
      foreach (tbl[i]) apply_vec(100 + i, tbl[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
